// File: rtl/core_pkg.sv
// Shared core types for the writeback path: datapath width, physical tag,
// ROB index and the writeback request payload.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int PREGS     = 64;
    localparam int ROB_DEPTH = 32;

    typedef logic [$clog2(PREGS)-1:0]     preg_tag_t;
    typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;

    typedef struct packed {
        preg_tag_t        tag;
        logic [XLEN-1:0]  data;
        rob_idx_t         rob_idx;
    } wb_req_t;

    // (a + b) mod n for a, b < n; n need not be a power of two
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned sum;
        sum = a + b;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source writeback result FIFO: circular buffer of wb_req_t entries with
// push/pop/flush and a registered occupancy count.
module wb_src_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  wb_req_t          wreq,
    input  logic             pop,
    output wb_req_t          head,
    output logic [CNT_W-1:0] count
);

    wb_req_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer, count and storage update; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wreq;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, two-port round-robin grant, registered
// PRF write ports. Optional perf counters under `WB_PERF_CNT_EN`.
module wb_arbiter #(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int PTAG_W     = $bits(core_pkg::preg_tag_t),
    parameter int ROB_W      = $bits(core_pkg::rob_idx_t)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       in_valid,
    output logic [NUM_SRC-1:0]       in_ready,
    input  logic [NUM_SRC*PTAG_W-1:0] in_tag,
    input  logic [NUM_SRC*XLEN-1:0]  in_data,
    input  logic [NUM_SRC*ROB_W-1:0] in_rob_idx,
    output logic                     wen0,
    output logic                     wen1,
    output logic [PTAG_W-1:0]        wtag0,
    output logic [PTAG_W-1:0]        wtag1,
    output logic [XLEN-1:0]          wdata0,
    output logic [XLEN-1:0]          wdata1,
    output logic [ROB_W-1:0]         cmp_rob_idx0,
    output logic [ROB_W-1:0]         cmp_rob_idx1
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_dual_wb_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    core_pkg::wb_req_t  head_s  [NUM_SRC];
    logic [CNT_W-1:0]   count_s [NUM_SRC];
    logic [NUM_SRC-1:0] push_s;
    logic [NUM_SRC-1:0] pop_s;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   rr_next_s;
    logic               g0_valid_s;
    logic               g1_valid_s;
    logic [SRC_W-1:0]   g0_idx_s;
    logic [SRC_W-1:0]   g1_idx_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        core_pkg::wb_req_t req_s;

        assign req_s = '{tag:     core_pkg::preg_tag_t'(in_tag[i*PTAG_W +: PTAG_W]),
                         data:    in_data[i*XLEN +: XLEN],
                         rob_idx: core_pkg::rob_idx_t'(in_rob_idx[i*ROB_W +: ROB_W])};
        // Ready looks only at the registered count, never at this cycle's pop
        assign in_ready[i] = (count_s[i] < CNT_W'(FIFO_DEPTH));
        assign push_s[i]   = in_valid[i] & in_ready[i];

        wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push_s[i]),
            .wreq  (req_s),
            .pop   (pop_s[i]),
            .head  (head_s[i]),
            .count (count_s[i])
        );
    end

    // Round-robin scan from rr_ptr; first non-empty source to port 0, next to port 1
    always_comb begin
        int idx_v;
        idx_v      = 0;
        g0_valid_s = 1'b0;
        g1_valid_s = 1'b0;
        g0_idx_s   = '0;
        g1_idx_s   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_v = int'(core_pkg::wrap_add(int'(rr_ptr_r), k, NUM_SRC));
            if (count_s[idx_v] != '0) begin
                if (!g0_valid_s) begin
                    g0_valid_s = 1'b1;
                    g0_idx_s   = SRC_W'(idx_v);
                end else if (!g1_valid_s) begin
                    g1_valid_s = 1'b1;
                    g1_idx_s   = SRC_W'(idx_v);
                end else begin
                    g1_valid_s = g1_valid_s;
                end
            end else begin
                idx_v = idx_v;
            end
        end
    end

    // Pop decode and next round-robin pointer (one past the last grant)
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop_s[i] = (g0_valid_s && (g0_idx_s == SRC_W'(i))) ||
                       (g1_valid_s && (g1_idx_s == SRC_W'(i)));
        end
        if (g1_valid_s) begin
            rr_next_s = SRC_W'(core_pkg::wrap_add(int'(g1_idx_s), 1, NUM_SRC));
        end else begin
            rr_next_s = SRC_W'(core_pkg::wrap_add(int'(g0_idx_s), 1, NUM_SRC));
        end
    end

    // Round-robin pointer register; a flush keeps the current position
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (flush) begin
            rr_ptr_r <= rr_ptr_r;
        end else if (g0_valid_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // PRF write-port and completion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wen0         <= 1'b0;
            wen1         <= 1'b0;
            wtag0        <= '0;
            wtag1        <= '0;
            wdata0       <= '0;
            wdata1       <= '0;
            cmp_rob_idx0 <= '0;
            cmp_rob_idx1 <= '0;
        end else if (flush) begin
            wen0 <= 1'b0;
            wen1 <= 1'b0;
        end else begin
            wen0 <= g0_valid_s;
            wen1 <= g1_valid_s;
            if (g0_valid_s) begin
                wtag0        <= PTAG_W'(head_s[g0_idx_s].tag);
                wdata0       <= head_s[g0_idx_s].data;
                cmp_rob_idx0 <= ROB_W'(head_s[g0_idx_s].rob_idx);
            end
            if (g1_valid_s) begin
                wtag1        <= PTAG_W'(head_s[g1_idx_s].tag);
                wdata1       <= head_s[g1_idx_s].data;
                cmp_rob_idx1 <= ROB_W'(head_s[g1_idx_s].rob_idx);
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    logic stall_any_s;
    assign stall_any_s = |(in_valid & ~in_ready);

    // Saturating perf counters; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt   <= 32'd0;
            perf_dual_wb_cnt <= 32'd0;
        end else begin
            if (stall_any_s && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (wen0 && wen1 && (perf_dual_wb_cnt != 32'hFFFF_FFFF)) begin
                perf_dual_wb_cnt <= perf_dual_wb_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a queue-based
// behavioural model, with directed scenarios pinned by literal expectations.
module tb_wb_arbiter;
    import core_pkg::*;

    localparam int NS    = 4;
    localparam int DEPTH = 2;
    localparam int TW    = $bits(preg_tag_t);
    localparam int RW    = $bits(rob_idx_t);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, flush;
    logic [NS-1:0]      in_valid, in_ready;
    logic [NS*TW-1:0]   in_tag;
    logic [NS*XLEN-1:0] in_data;
    logic [NS*RW-1:0]   in_rob_idx;
    logic               wen0, wen1;
    logic [TW-1:0]      wtag0, wtag1;
    logic [XLEN-1:0]    wdata0, wdata1;
    logic [RW-1:0]      cmp_rob_idx0, cmp_rob_idx1;
`ifdef WB_PERF_CNT_EN
    logic [31:0]        perf_stall_cnt, perf_dual_wb_cnt;
`endif

    wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .in_data      (in_data),
        .in_rob_idx   (in_rob_idx),
        .wen0         (wen0),
        .wen1         (wen1),
        .wtag0        (wtag0),
        .wtag1        (wtag1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .cmp_rob_idx0 (cmp_rob_idx0),
        .cmp_rob_idx1 (cmp_rob_idx1)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_dual_wb_cnt (perf_dual_wb_cnt)
`endif
    );

    typedef struct packed {
        logic [TW-1:0]   tag;
        logic [XLEN-1:0] data;
        logic [RW-1:0]   rob;
    } ent_t;

    ent_t mq [NS][$];
    ent_t pay [NS];
    int   mrr;
    bit   exp_wen0, exp_wen1, exp_zero;
    ent_t exp_e0, exp_e1;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit mready(input int i);
        return mq[i].size() < DEPTH;
    endfunction

    // Model of one clock edge: grants on pre-edge occupancy, then accepted pushes
    task automatic model_edge(input bit rst, input bit fl, input logic [NS-1:0] v);
        bit rdy [NS];
        int g [2];
        int ng;
        for (int i = 0; i < NS; i++) rdy[i] = mready(i);
        if (rst || fl) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            if (rst) mrr = 0;
            exp_wen0 = 1'b0;
            exp_wen1 = 1'b0;
            exp_zero = rst;
        end else begin
            exp_zero = 1'b0;
            ng = 0;
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (mrr + k) % NS;
                if (mq[s].size() > 0 && ng < 2) begin
                    g[ng] = s;
                    ng++;
                end
            end
            exp_wen0 = (ng > 0);
            exp_wen1 = (ng > 1);
            if (ng > 0) exp_e0 = mq[g[0]].pop_front();
            if (ng > 1) exp_e1 = mq[g[1]].pop_front();
            if (ng > 0) mrr = (g[ng-1] + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                if (v[i] && rdy[i]) mq[i].push_back(pay[i]);
            end
        end
    endtask

    task automatic compare();
        logic [NS-1:0] rdy;
        for (int i = 0; i < NS; i++) rdy[i] = mready(i);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("wen0", 64'(wen0), 64'(exp_wen0));
        check("wen1", 64'(wen1), 64'(exp_wen1));
        if (exp_wen0) begin
            check("wtag0", 64'(wtag0), 64'(exp_e0.tag));
            check("wdata0", 64'(wdata0), 64'(exp_e0.data));
            check("cmp_rob_idx0", 64'(cmp_rob_idx0), 64'(exp_e0.rob));
        end
        if (exp_wen1) begin
            check("wtag1", 64'(wtag1), 64'(exp_e1.tag));
            check("wdata1", 64'(wdata1), 64'(exp_e1.data));
            check("cmp_rob_idx1", 64'(cmp_rob_idx1), 64'(exp_e1.rob));
        end
        if (exp_zero) begin
            check("reset_outs", {wtag0, wtag1, cmp_rob_idx0, cmp_rob_idx1}, 64'd0);
            check("reset_data", {wdata0, wdata1}, 64'd0);
        end
    endtask

    task automatic step(input bit rst, input bit fl, input logic [NS-1:0] v);
        reset    = rst;
        flush    = fl;
        in_valid = v;
        for (int i = 0; i < NS; i++) begin
            in_tag[i*TW +: TW]       = pay[i].tag;
            in_data[i*XLEN +: XLEN]  = pay[i].data;
            in_rob_idx[i*RW +: RW]   = pay[i].rob;
        end
        model_edge(rst, fl, v);
        @(posedge clk);
        #1;
        compare();
    endtask

    function automatic ent_t mk(input int t, input logic [XLEN-1:0] d, input int r);
        ent_t e;
        e.tag  = TW'(t);
        e.data = d;
        e.rob  = RW'(r);
        return e;
    endfunction

    initial begin
        int acc;
        for (int i = 0; i < NS; i++) pay[i] = '0;
        mrr = 0;
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
`ifdef WB_PERF_CNT_EN
        check("perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
        check("perf_dual_rst", 64'(perf_dual_wb_cnt), 64'd0);
`endif

        // Single result through src1: visible two edges after the push
        step(1'b0, 1'b0, 4'h0);
        pay[1] = mk(8'h12, 32'hDEAD_BEEF, 5);
        step(1'b0, 1'b0, 4'b0010);
        check("single_n1_wen0", 64'(wen0), 64'd0);
        step(1'b0, 1'b0, 4'h0);
        check("single_wen0", 64'(wen0), 64'd1);
        check("single_wtag0", 64'(wtag0), 64'h12);
        check("single_wdata0", 64'(wdata0), 64'hDEAD_BEEF);
        check("single_rob0", 64'(cmp_rob_idx0), 64'd5);
        check("single_wen1", 64'(wen1), 64'd0);

        // Four-way contention from rr_ptr = 0
        step(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < NS; i++) pay[i] = mk(8'h20 + i, 32'h1000 + i, 8 + i);
        step(1'b0, 1'b0, 4'hF);
        step(1'b0, 1'b0, 4'h0);
        check("cont_a_tag0", 64'(wtag0), 64'h20);
        check("cont_a_tag1", 64'(wtag1), 64'h21);
        step(1'b0, 1'b0, 4'h0);
        check("cont_b_tag0", 64'(wtag0), 64'h22);
        check("cont_b_tag1", 64'(wtag1), 64'h23);
        pay[0] = mk(8'h30, 32'h3000, 1);
        pay[3] = mk(8'h33, 32'h3333, 2);
        step(1'b0, 1'b0, 4'b1001);
        step(1'b0, 1'b0, 4'h0);
        check("cont_rr0_tag0", 64'(wtag0), 64'h30);
        check("cont_rr0_tag1", 64'(wtag1), 64'h33);

        // Backpressure on src3 while all sources push
        step(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < NS; i++) pay[i] = mk(8'h08 + i, 32'h0000_5000 + i, i);
        pay[3] = mk(8'h31, 32'hB0B0_0001, 17);
        step(1'b0, 1'b0, 4'hF);
        pay[3] = mk(8'h32, 32'hB0B0_0002, 18);
        step(1'b0, 1'b0, 4'hF);
        check("bp_ready", 64'(in_ready), 64'b0011);
        acc = 2;
        pay[3] = mk(8'h33, 32'hB0B0_0003, 19);
        for (int c = 0; c < 20 && acc < 3; c++) begin
            if (mready(3)) acc++;
            step(1'b0, 1'b0, 4'hF);
        end
        check("bp_accepted", 64'(acc), 64'd3);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 4'h0);

        // Wrap-around: six single-source pushes through src0
        for (int n = 0; n < 6; n++) begin
            pay[0] = mk(8'h10 + n, 32'hC0DE_0000 + n, n);
            step(1'b0, 1'b0, 4'b0001);
        end
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 4'h0);

        // Flush drops buffered src2 entries and a same-cycle push
        step(1'b1, 1'b0, 4'h0);
        pay[2] = mk(8'h2A, 32'h2A2A_2A2A, 3);
        step(1'b0, 1'b0, 4'b0100);
        pay[2] = mk(8'h2B, 32'h2B2B_2B2B, 4);
        step(1'b0, 1'b0, 4'b0100);
        pay[1] = mk(8'h3F, 32'hFFFF_0000, 7);
        step(1'b0, 1'b1, 4'b0110);
        check("flush_wen0", 64'(wen0), 64'd0);
        check("flush_wen1", 64'(wen1), 64'd0);
        check("flush_ready", 64'(in_ready), 64'hF);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 4'h0);
            check("flush_no_write", 64'(wen0), 64'd0);
        end

        // Reset while both ports are writing
        for (int i = 0; i < NS; i++) pay[i] = mk(8'h01 + i, 32'h7700 + i, i);
        step(1'b0, 1'b0, 4'hF);
        step(1'b0, 1'b0, 4'hF);
        check("mid_dual_wen", {wen0, wen1}, 64'd3);
        step(1'b1, 1'b0, 4'hF);
        check("mid_rst_outs", {wen0, wen1, wtag0, wtag1, cmp_rob_idx0, cmp_rob_idx1}, 64'd0);
        check("mid_rst_data", {wdata0, wdata1}, 64'd0);
`ifdef WB_PERF_CNT_EN
        check("mid_perf_stall", 64'(perf_stall_cnt), 64'd0);
        check("mid_perf_dual", 64'(perf_dual_wb_cnt), 64'd0);
`endif

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            logic [NS-1:0] v;
            bit fl, rst;
            v   = NS'($urandom);
            fl  = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NS; i++) pay[i] = mk($urandom, $urandom, $urandom);
            step(rst, fl, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter between the functional-unit result buses and the physical register file's two write ports.
- Buffers results from NUM_SRC execution sources (ALU0, ALU1, MUL, LSU by default) in per-source FIFOs.
- Grants up to two results per cycle by round-robin and drives registered write-enable/tag/data pairs to the PRF, plus ROB completion indices.
- Absorbs writeback-port contention so FUs only stall on a full FIFO.

Parameters:
- XLEN, core_pkg::XLEN, datapath width.
- NUM_SRC, 4, number of result sources (2..8).
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2).
- PTAG_W, $bits(core_pkg::preg_tag_t), physical tag width.
- ROB_W, $bits(core_pkg::rob_idx_t), ROB index width.

Ports:
- clk  in  1  core clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; drops all buffered results.
- in_valid  in  NUM_SRC  per-source result valid.
- in_ready  out  NUM_SRC  per-source FIFO can accept.
- in_tag  in  NUM_SRC x PTAG_W  destination physical tag.
- in_data  in  NUM_SRC x XLEN  result value.
- in_rob_idx  in  NUM_SRC x ROB_W  ROB entry to mark complete.
- wen0, wen1  out  1  PRF write enables.
- wtag0, wtag1  out  PTAG_W  PRF write tags.
- wdata0, wdata1  out  XLEN  PRF write data.
- cmp_rob_idx0, cmp_rob_idx1  out  ROB_W  completion index, valid with wen0/wen1.

Behaviour:
- Handshake: source i pushes when in_valid[i] && in_ready[i] on a rising clk.
- in_ready[i] = (count[i] < FIFO_DEPTH), computed from registered count only; a same-cycle pop does not raise in_ready.
- FIFO per source: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leaves count unchanged.
- Arbitration (combinational, on registered FIFO state):
  - Candidate set = sources with count > 0.
  - Port 0 gets the first candidate scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Port 1 gets the next candidate after the port-0 grant in the same scan order.
  - A source is granted at most once per cycle, even with >1 entry.
- Output register (1-cycle latency):
  - Granted heads are popped and appear on wen/wtag/wdata/cmp_rob_idx the next cycle.
  - Port 0 always carries the first grant; wen1 is never 1 while wen0 is 0.
  - An entry pushed in cycle N appears at the output no earlier than cycle N+2 (registered FIFO, then registered output).
- rr_ptr: advances to (last granted index + 1) mod NUM_SRC; unchanged when nothing is granted.
- Tags: no duplicate-tag check. Rename guarantees unique in-flight tags; if duplicates occur, both are output as-is.
- Flush (synchronous, priority below reset):
  - Next cycle: all counts and pointers = 0; wen0 = wen1 = 0.
  - Pushes and grants in the flush cycle are discarded.
  - rr_ptr is kept.
- Reset (also mid-operation): all FIFOs empty, rr_ptr = 0, wen0/wen1 = 0, wtag*/wdata*/cmp_rob_idx* = 0, in_ready = all ones from the first cycle after reset.

Optional Feature:
- WB_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cnt (32 bits), which increments each cycle any in_valid[i] && !in_ready[i].
  - Adds perf_dual_wb_cnt (32 bits), which increments each cycle both wen0 and wen1 are asserted.
  - Both counters saturate at all-ones and clear on reset only, not on flush.
- WB_PERF_CNT_EN undefined: the ports and counters do not exist.

Decomposition:
- core_pkg holds XLEN, PREGS, preg_tag_t, rob_idx_t, and the struct wb_req_t {tag, data, rob_idx}.
- Sub-module wb_src_fifo: one per source, wb_req_t payload, FIFO_DEPTH entries, with push/pop/flush/count and synchronous reset.
- Arbiter and output registers live in wb_arbiter.

Test Plan:
- Single result: reset, then src1 pushes tag 0x12, data 0xDEAD_BEEF, rob 5 at cycle 3. Required: wen0=1, wtag0=0x12, wdata0=0xDEADBEEF, cmp_rob_idx0=5 at cycle 5; wen1=0.
- Four-way contention: all 4 sources push at once with rr_ptr=0. Required: cycle+2 gives src0 on port 0 and src1 on port 1; cycle+3 gives src2 and src3; rr_ptr ends at 0.
- Backpressure: src3 pushes 3 back-to-back with other sources saturating grants. Required: in_ready[3] drops after 2 accepted (FIFO_DEPTH=2); the third is held until ready returns; all three are written in order with no loss.
- Wrap-around: 6 pushes through src0 alone, one per cycle. Required: outputs appear in order on port 0 only, pointers wrap, and count never exceeds 2.
- Flush: 2 entries buffered in src2, then flush. Required: next cycle wen0=wen1=0 and in_ready all ones; a push made in the flush cycle is never written.
- Reset mid-operation: reset asserted while wen0=wen1=1. Required: next cycle all outputs 0 and rr_ptr=0; with WB_PERF_CNT_EN, both counters read 0.
